// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetches, buffers responses with their PC,
// flushes on redirect. Optional same-cycle response forwarding when FETCHQ_BYPASS_EN is defined.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_incpc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   pc_reg;
  logic          inflight_reg;
  logic [31:0]   inflight_addr_reg;
  logic          kill_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];

  logic          live;
  logic          fifo_empty;
  logic          fifo_full;
  logic          raw_valid;
  logic          push;
  logic          do_push;
  logic          pop;
  logic          fifo_pop;
  logic [31:0]   sel_instr;
  logic [31:0]   sel_pc;
  logic [CW:0]   occupancy;

  // A response is live when a request went out last cycle and nothing has discarded it.
  assign live       = inflight_reg & ~kill_reg & ~redirect;
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == DEPTH_W[CW-1:0]);

`ifdef FETCHQ_BYPASS_EN
  logic bypass;
  assign bypass    = live & fifo_empty;
  assign raw_valid = ~fifo_empty | bypass;
  assign sel_instr = fifo_empty ? imem_rdata        : instr_mem[rd_ptr_reg];
  assign sel_pc    = fifo_empty ? inflight_addr_reg : pc_mem[rd_ptr_reg];
  // A forwarded word consumed by decode this cycle never enters the FIFO.
  assign push      = live & ~(bypass & out_ready);
`else
  assign raw_valid = ~fifo_empty;
  assign sel_instr = instr_mem[rd_ptr_reg];
  assign sel_pc    = pc_mem[rd_ptr_reg];
  assign push      = live;
`endif

  assign out_valid = rst & raw_valid;
  assign pop       = out_valid & out_ready;
  assign fifo_pop  = pop & ~fifo_empty;
  assign do_push   = push & (~fifo_full | fifo_pop);

  // Occupancy after this cycle, counting the response still on its way back.
  assign occupancy = {1'b0, count_reg}
                   + {{CW{1'b0}}, inflight_reg}
                   - {{CW{1'b0}}, pop};
  assign imem_req  = rst & ~redirect & (occupancy < DEPTH_W);
  assign imem_addr = pc_reg;

  assign out_instr = out_valid ? sel_instr        : 32'h0;
  assign out_pc    = out_valid ? sel_pc           : 32'h0;
  assign out_incpc = out_valid ? sel_pc + 32'd4   : 32'h0;
  assign count     = count_reg;

  always_comb begin
    count_next = count_reg;
    if (redirect) begin
      count_next = '0;
    end else begin
      count_next = count_reg + CW'(do_push) - CW'(fifo_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_reg            <= RESET_PC;
      inflight_reg      <= 1'b0;
      inflight_addr_reg <= 32'h0;
      kill_reg          <= 1'b0;
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      count_reg         <= '0;
    end else begin
      inflight_reg <= imem_req;
      kill_reg     <= redirect;
      count_reg    <= count_next;
      if (imem_req) begin
        inflight_addr_reg <= pc_reg;
      end
      if (redirect) begin
        pc_reg     <= redirect_pc & 32'hFFFF_FFFC;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (imem_req) begin
          pc_reg <= pc_reg + 32'd4;
        end
        if (do_push) begin
          wr_ptr_reg <= wr_ptr_reg + 1'b1;
        end
        if (fifo_pop) begin
          rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
      end
    end
  end

  // Entry storage carries no reset; stale contents are masked by count.
  always_ff @(posedge clk) begin
    if (rst && !redirect && do_push) begin
      instr_mem[wr_ptr_reg] <= imem_rdata;
      pc_mem[wr_ptr_reg]    <= inflight_addr_reg;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, backpressure, full FIFO, redirect,
// mid-stream reset, and PC wrap on a second instance with RESET_PC near the top.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_incpc;
  logic [2:0]  count;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_incpc;
  logic [2:0]  w_count;

  logic [31:0] dmask;
  int          checks;
  int          errors;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_incpc(out_incpc),
    .count(count)
  );

  fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .redirect(1'b0), .redirect_pc(32'h0),
    .out_valid(w_valid), .out_ready(1'b1),
    .out_instr(w_instr), .out_pc(w_pc), .out_incpc(w_incpc),
    .count(w_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: returns the (masked) address one cycle after a request.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr ^ dmask) : 32'hBAD0_BAD0;
    w_rdata    <= w_req ? w_addr : 32'hBAD0_BAD0;
  end

  always @(posedge clk) begin
    if (rst && out_valid && out_ready)
      $display("pop pc=%08h instr=%08h count=%0d", out_pc, out_instr, count);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    out_ready   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    dmask       = 32'h0;
    repeat (3) tick();
    #1;
    chk("rst_req",   32'(imem_req),  32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count),     32'd0);
    chk("rst_instr", out_instr,      32'd0);
    chk("rst_wreq",  32'(w_req),     32'd0);

    rst = 1'b1;
    #1;
    chk("c0_req",   32'(imem_req),  32'd1);
    chk("c0_addr",  imem_addr,      32'h0);
    chk("c0_valid", 32'(out_valid), 32'd0);
    tick(); #1;
    chk("c1_addr",  imem_addr,      32'h4);
    chk("c1_valid", 32'(out_valid), 32'd0);
    tick(); #1;

    // Steady stream: one instruction per cycle from cycle 2.
    for (int i = 0; i < 6; i++) begin
      chk("st_valid", 32'(out_valid), 32'd1);
      chk("st_pc",    out_pc,         32'(4*i));
      chk("st_instr", out_instr,      32'(4*i));
      chk("st_incpc", out_incpc,      32'(4*i + 4));
      chk("st_count", 32'(count),     32'd1);
      chk("st_addr",  imem_addr,      32'(4*i + 8));
      if (i < 3) begin
        chk("wrap_pc",    w_pc,    32'hFFFF_FFF8 + 32'(4*i));
        chk("wrap_incpc", w_incpc, 32'hFFFF_FFFC + 32'(4*i));
      end
      if (i == 0) chk("wrap_addr", w_addr, 32'h0);
      tick(); #1;
    end

    // Backpressure: ten stalled cycles fill the FIFO and stop requests.
    out_ready = 1'b0;
    #1;
    chk("bp_req0", 32'(imem_req), 32'd1);
    repeat (10) tick();
    #1;
    chk("full_count", 32'(count),     32'd4);
    chk("full_req",   32'(imem_req),  32'd0);
    chk("full_valid", 32'(out_valid), 32'd1);
    chk("full_pc",    out_pc,         32'd24);
    chk("full_addr",  imem_addr,      32'd40);
    out_ready = 1'b1;
    #1;
    chk("rel_req",  32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr,     32'd40);
    tick(); #1;
    for (int i = 0; i < 5; i++) begin
      chk("rel_pc",    out_pc,     32'(28 + 4*i));
      chk("rel_instr", out_instr,  32'(28 + 4*i));
      chk("rel_count", 32'(count), 32'd3);
      chk("rel_addr",  imem_addr,  32'(44 + 4*i));
      tick(); #1;
    end

    // Top up to full, then pop while refilling: count never exceeds DEPTH.
    out_ready = 1'b0;
    #1;
    chk("top_req",   32'(imem_req), 32'd0);
    chk("top_count", 32'(count),    32'd3);
    tick(); #1;
    chk("f2_count", 32'(count),    32'd4);
    chk("f2_pc",    out_pc,        32'd48);
    chk("f2_req",   32'(imem_req), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("f2_popreq", 32'(imem_req), 32'd1);
    chk("f2_addr",   imem_addr,     32'd64);
    tick(); #1;
    chk("f3_count", 32'(count), 32'd3);
    chk("f3_pc",    out_pc,     32'd52);
    tick(); #1;
    chk("f4_count", 32'(count), 32'd3);
    chk("f4_pc",    out_pc,     32'd56);

    // Redirect with three entries buffered and one response in flight.
    dmask       = 32'h5A00_0000;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    chk("rd_req", 32'(imem_req), 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    chk("rd1_count", 32'(count),     32'd0);
    chk("rd1_valid", 32'(out_valid), 32'd0);
    chk("rd1_pc0",   out_pc,         32'h0);
    chk("rd1_inc0",  out_incpc,      32'h0);
    chk("rd1_ins0",  out_instr,      32'h0);
    chk("rd1_req",   32'(imem_req),  32'd1);
    chk("rd1_addr",  imem_addr,      32'h100);
    tick(); #1;
    chk("rd2_valid", 32'(out_valid), 32'd0);
    chk("rd2_count", 32'(count),     32'd0);
    chk("rd2_addr",  imem_addr,      32'h104);
    tick(); #1;
    chk("rd3_valid", 32'(out_valid), 32'd1);
    chk("rd3_pc",    out_pc,         32'h100);
    chk("rd3_instr", out_instr,      32'h5A00_0100);
    chk("rd3_incpc", out_incpc,      32'h104);
    tick(); #1;
    chk("rd4_pc",    out_pc,     32'h104);
    chk("rd4_count", 32'(count), 32'd1);

    // One-cycle reset in mid-stream.
    rst = 1'b0;
    #1;
    chk("mr_req",   32'(imem_req),  32'd0);
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_instr", out_instr,      32'h0);
    tick();
    rst = 1'b1;
    #1;
    chk("mr1_count", 32'(count),     32'd0);
    chk("mr1_valid", 32'(out_valid), 32'd0);
    chk("mr1_req",   32'(imem_req),  32'd1);
    chk("mr1_addr",  imem_addr,      32'h0);
    chk("mr1_waddr", w_addr,         32'hFFFF_FFF8);
    tick(); #1;
    chk("mr2_valid", 32'(out_valid), 32'd0);
    chk("mr2_addr",  imem_addr,      32'h4);
    tick(); #1;
    chk("mr3_valid", 32'(out_valid), 32'd1);
    chk("mr3_pc",    out_pc,         32'h0);
    chk("mr3_instr", out_instr,      32'h5A00_0000);
    chk("mr3_wpc",   w_pc,           32'hFFFF_FFF8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
